// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-port arbiter sharing one combinational ALU
//
// Purpose: arbitrates between requester 0 (core sequencer) and requester 1
// (comm/accelerator port), registers the winning operands onto the ALU
// inputs, captures ALUResult/Zero one cycle later and returns them to the
// winner over a valid/ready response channel. FSM: IDLE -> EXEC -> RESP.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   reqN_valid/ready                  request handshake, N in {0,1}
//   reqN_SrcA/SrcB/ALUControl         request payload (sampled at handshake)
//   rspN_valid/ready                  response handshake
//   rspN_Result/Zero                  captured ALU result for requester N
//   alu_SrcA/SrcB/ALUControl          registered operands to the ALU
//   alu_Result/alu_Zero               combinational ALU outputs
//   busy                              FSM not in IDLE
//   owner                             requester currently being served
//
// Configuration: define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0
// always wins a tie); default is round-robin on simultaneous requests.

module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_SrcA,
    input  logic [DATA_W-1:0] req0_SrcB,
    input  logic [CTRL_W-1:0] req0_ALUControl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_SrcA,
    input  logic [DATA_W-1:0] req1_SrcB,
    input  logic [CTRL_W-1:0] req1_ALUControl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_Result,
    output logic              rsp0_Zero,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_Result,
    output logic              rsp1_Zero,
    output logic [DATA_W-1:0] alu_SrcA,
    output logic [DATA_W-1:0] alu_SrcB,
    output logic [CTRL_W-1:0] alu_ALUControl,
    input  logic [DATA_W-1:0] alu_Result,
    input  logic              alu_Zero,
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] src_a_q, src_b_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] res0_q, res1_q;
    logic              zero0_q, zero1_q;

    logic idle;
    logic grant;
    logic hs;
    logic rsp_take;

    assign idle = (state_q == S_IDLE);

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Port 0 wins whenever it is valid; port 1 may starve.
    assign grant = ~req0_valid;
`else
    logic rr_ptr_q, rr_ptr_d;
    // Tie goes to rr_ptr; otherwise the sole valid port.
    assign grant = (req0_valid & req1_valid) ? rr_ptr_q : req1_valid;
`endif

    // Gated by rst_n so that every output reads 0 while reset is held.
    assign req0_ready = rst_n & idle & req0_valid & ~grant;
    assign req1_ready = rst_n & idle & req1_valid &  grant;
    assign hs         = req0_ready | req1_ready;

    assign rsp_take = (state_q == S_RESP) & (owner_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    state_d = S_EXEC;
                    owner_d = grant;
                end
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: begin
                if (rsp_take) begin
                    state_d = S_IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    // The port just served yields the next tie.
                    rr_ptr_d = ~owner_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q <= 1'b0;
`endif
            src_a_q <= '0;
            src_b_q <= '0;
            ctrl_q  <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            zero0_q <= 1'b0;
            zero1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
            if (hs) begin
                src_a_q <= grant ? req1_SrcA       : req0_SrcA;
                src_b_q <= grant ? req1_SrcB       : req0_SrcB;
                ctrl_q  <= grant ? req1_ALUControl : req0_ALUControl;
            end
            // Only the owner's result registers change; the other port keeps
            // its last delivered value.
            if (state_q == S_EXEC) begin
                if (owner_q) begin
                    res1_q  <= alu_Result;
                    zero1_q <= alu_Zero;
                end else begin
                    res0_q  <= alu_Result;
                    zero0_q <= alu_Zero;
                end
            end
        end
    end

    assign alu_SrcA       = src_a_q;
    assign alu_SrcB       = src_b_q;
    assign alu_ALUControl = ctrl_q;

    assign rsp0_valid  = (state_q == S_RESP) & ~owner_q;
    assign rsp1_valid  = (state_q == S_RESP) &  owner_q;
    assign rsp0_Result = res0_q;
    assign rsp0_Zero   = zero0_q;
    assign rsp1_Result = res1_q;
    assign rsp1_Zero   = zero1_q;

    assign busy  = ~idle;
    assign owner = owner_q;

endmodule
